yapp_router_mc: RTL and testbench
=================================

# yapp_router_mc

Parametrised multi-channel YAPP packet router: accepts YAPP packets (header, payload, parity) on one 8-bit input stream and steers each whole packet into one of NUM_CHAN output FIFOs. A header is admitted only when the target FIFO can hold the entire packet, so an admitted packet streams without stalls. Illegal-address, disabled-channel and oversized packets are consumed and dropped, and parity errors are flagged. The block replaces the fixed 3-channel router core under the same top level; register access stays outside it.

## Interface
- NUM_CHAN, 3, number of output channels, legal range 1..4 (header address field is 2 bits)
- FIFO_DEPTH, 128, entries per channel FIFO; power of two, at least 65 (one header, 63 payload bytes and parity)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_data  in  8  input byte
- in_data_vld  in  1  input byte valid
- in_suspend  out  1  input stall; a byte transfers on a clock edge with in_data_vld=1 and in_suspend=0
- error  out  1  one-cycle parity-error pulse
- chan_en  in  NUM_CHAN  per-channel enable; quasi-static
- max_pkt_len  in  6  largest legal payload length; quasi-static
- data_out  out  8*NUM_CHAN  channel i head byte on bits [8i+7:8i]
- data_vld  out  NUM_CHAN  channel i FIFO is non-empty
- suspend  in  NUM_CHAN  channel i receiver stall
- parity_err_cnt, len_err_cnt, ill_addr_cnt  out  8 each  saturating event counters

## Operation
- Header format: addr = hdr[1:0], len = hdr[7:2]. Packet = header, then len payload bytes, then parity. Parity = XOR of header and all payload bytes.
- States (in yapp_router_pkg): IDLE, WAIT_SPACE, FWD, PAR, DROP.
- **IDLE**, in_data_vld=1, header is classified:
  - Illegal: addr >= NUM_CHAN, or chan_en[addr]=0. The header is consumed; ill_addr_cnt increments; go to DROP.
  - Oversized: len > max_pkt_len. The header is consumed; len_err_cnt increments; go to DROP.
  - Legal, target FIFO free >= len+2: the header is consumed and written to the target FIFO; latch target and len; go to FWD (go to PAR if len=0).
  - Legal, insufficient space: in_suspend=1; go to WAIT_SPACE.
  - Illegal takes priority over oversized. Each event increments exactly one counter.
- **WAIT_SPACE**: in_suspend=1; the header is held on the input. When free >= len+2, go to IDLE and re-evaluate.
- **FWD**: each accepted byte is written to the target FIFO and folded into the running parity. After the len-th byte, go to PAR. Gaps (in_data_vld=0) are allowed anywhere.
- **PAR**: the accepted byte is written to the FIFO. On mismatch: error=1 on the next cycle and parity_err_cnt increments. The packet is still delivered. Go to IDLE.
- **DROP**: consumes len+1 further bytes without writing any FIFO, then goes to IDLE.
- in_suspend: 1 only in WAIT_SPACE, or in IDLE with a legal header and insufficient space; 0 otherwise. It depends combinationally on in_data in IDLE.
- Output channel i:
  - data_vld[i] = FIFO non-empty; data_out = FIFO head (first-word fall-through).
  - A pop occurs on an edge with data_vld[i]=1 and suspend[i]=0.
  - Simultaneous push and pop are both performed. Free space counts pops from the same cycle only from the next cycle.
- Counters saturate at 255.

## Timing
- Reset values:
  - State IDLE; all FIFO pointers and counts 0.
  - data_vld=0, error=0, counters=0.
  - in_suspend follows the IDLE rule.
  - data_out is undefined while data_vld=0.
- Latency: a byte accepted at edge t appears at its channel head by edge t+1 (data_vld=1 after edge t). There is no fixed input-to-output latency beyond that.
- Throughput: one byte per cycle in and one byte per cycle per channel out.
- Pointers wrap modulo FIFO_DEPTH; the count distinguishes full from empty. A push to a full FIFO cannot happen because of the admission check.
- Reset asserted mid-packet discards all FIFO contents and the partial packet. The next accepted byte is treated as a header.

## Configuration
- YAPP_STATS_EN defined: the three counters are implemented as specified.
- YAPP_STATS_EN undefined: counter ports remain present but are driven constant 0, and no counter registers exist. Drop and error behaviour is unchanged.

## Structure
- yapp_router_pkg holds:
  - the state enum;
  - header field positions;
  - YAPP_MAX_LEN=63;
  - the counter width constant.
- Sub-module yapp_chan_fifo (parameter DEPTH; ports: push, pop, din, dout, empty, free count) is instantiated NUM_CHAN times via generate.
- The input FSM, parity and counters live in the top level.

## Test plan
- NUM_CHAN=3, max_pkt_len=63, header 0x0D (addr 1, len 3), payload 01 02 03, parity 0x0D -> channel 1 outputs 0D 01 02 03 0D; error stays 0; counters stay 0.
- Header 0x0F (addr 3) with 3 payload bytes and parity -> all bytes consumed, no FIFO written, ill_addr_cnt=1. The following legal packet is delivered intact.
- max_pkt_len=4, header 0x14 (len 5) -> 6 further bytes dropped, len_err_cnt=1. The same packet with max_pkt_len=5 is delivered.
- Legal packet with parity byte XORed with 0x01 -> packet delivered, error pulses for exactly 1 cycle, parity_err_cnt=1.
- FIFO_DEPTH=128, suspend[0]=1, send two len-63 packets to channel 0:
  - second header is held with in_suspend=1;
  - release suspend[0] -> second packet admitted once 65 entries are free, no bytes lost.
- Reset pulled low mid-payload, then released -> data_vld=0, counters=0, next header routed correctly; 256 ill_addr events leave ill_addr_cnt=255.

Source files
------------

// File: rtl/yapp_router_pkg.sv
// Shared definitions for the YAPP multi-channel router: input FSM states,
// header field positions, protocol limits and event-counter helpers.
package yapp_router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPACE,
    FWD,
    PAR,
    DROP
  } state_e;

  // Header byte layout: {len[5:0], addr[1:0]}
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_W   = 2;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_W    = 6;

  localparam int YAPP_MAX_LEN = 63;

  localparam int CNT_W = 8;

  // Saturating increment for the event counters (sticks at all-ones).
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/yapp_chan_fifo.sv
// Per-channel output FIFO of the YAPP router. First-word fall-through:
// dout_o always shows the head entry while empty_o is low. free_o reports
// the number of unused entries; it reflects a pop only after the pop edge.
module yapp_chan_fifo #(
  parameter  int DEPTH = 128,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o,
  output logic          empty_o,
  output logic [AW:0]   free_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          pop_ok;

  assign pop_ok  = pop_i && (cnt_q != '0);
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_q];
  assign free_o  = (AW+1)'(DEPTH) - cnt_q;

  // Next pointer/occupancy values; pointers wrap naturally (DEPTH is 2^AW).
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_ok) rd_d = rd_q + 1'b1;
    case ({push_i, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/yapp_router_mc.sv
// YAPP multi-channel packet router top level. Classifies each header,
// admits a packet only when its target FIFO can hold all of it, drops
// illegal/disabled/oversized packets and flags parity errors.
// Optional build macro YAPP_STATS_EN: when defined, the three saturating
// event counters are implemented; otherwise the counter ports read 0.
module yapp_router_mc
  import yapp_router_pkg::*;
#(
  parameter int NUM_CHAN   = 3,
  parameter int FIFO_DEPTH = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_data_vld,
  output logic                  in_suspend,
  output logic                  error,
  input  logic [NUM_CHAN-1:0]   chan_en,
  input  logic [5:0]            max_pkt_len,
  output logic [8*NUM_CHAN-1:0] data_out,
  output logic [NUM_CHAN-1:0]   data_vld,
  input  logic [NUM_CHAN-1:0]   suspend,
  output logic [CNT_W-1:0]      parity_err_cnt,
  output logic [CNT_W-1:0]      len_err_cnt,
  output logic [CNT_W-1:0]      ill_addr_cnt
);

  localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;

  state_e                  state_q;
  logic [HDR_ADDR_W-1:0]   tgt_q;
  logic [HDR_LEN_W-1:0]    len_q;
  logic [HDR_LEN_W:0]      rem_q;
  logic [7:0]              par_q;
  logic                    err_q;

  logic [HDR_ADDR_W-1:0]   hdr_addr;
  logic [HDR_LEN_W-1:0]    hdr_len;
  logic [HDR_ADDR_W-1:0]   sel_addr;
  logic [HDR_LEN_W-1:0]    sel_len;
  logic                    sel_en;
  logic [FREE_W-1:0]       sel_free;
  logic [FREE_W:0]         need;
  logic                    space_ok;
  logic                    hdr_illegal;
  logic                    hdr_oversize;
  logic                    accept;
  logic                    push_en;
  logic [HDR_ADDR_W-1:0]   push_addr;
  logic                    ev_par;

  logic [FREE_W-1:0]       free_w [NUM_CHAN];
  logic [NUM_CHAN-1:0]     empty_w;
  logic [NUM_CHAN-1:0]     push_w;
  logic [NUM_CHAN-1:0]     pop_w;

  assign hdr_addr = in_data[HDR_ADDR_LSB +: HDR_ADDR_W];
  assign hdr_len  = in_data[HDR_LEN_LSB  +: HDR_LEN_W];

  // While waiting for space the latched header decides; in IDLE the live byte does.
  assign sel_addr = (state_q == WAIT_SPACE) ? tgt_q : hdr_addr;
  assign sel_len  = (state_q == WAIT_SPACE) ? len_q : hdr_len;

  // Look up enable and free space of the addressed channel. An address at or
  // beyond NUM_CHAN matches no channel and so reads as disabled.
  always_comb begin
    sel_en   = 1'b0;
    sel_free = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (sel_addr == HDR_ADDR_W'(i)) begin
        sel_en   = chan_en[i];
        sel_free = free_w[i];
      end
    end
  end

  assign need         = (FREE_W+1)'(sel_len) + (FREE_W+1)'(2);
  assign space_ok     = {1'b0, sel_free} >= need;
  assign hdr_illegal  = !sel_en;
  assign hdr_oversize = hdr_len > max_pkt_len;

  assign in_suspend = (state_q == WAIT_SPACE) ||
                      ((state_q == IDLE) && in_data_vld &&
                       !hdr_illegal && !hdr_oversize && !space_ok);
  assign accept     = in_data_vld && !in_suspend;

  assign push_en   = accept && (((state_q == IDLE) && !hdr_illegal && !hdr_oversize) ||
                                (state_q == FWD) || (state_q == PAR));
  assign push_addr = (state_q == IDLE) ? hdr_addr : tgt_q;
  assign ev_par    = (state_q == PAR) && in_data_vld && (par_q != in_data);

  // Steer the accepted byte into the target channel FIFO.
  always_comb begin
    push_w = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (push_en && (push_addr == HDR_ADDR_W'(i))) push_w[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
    yapp_chan_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .push_i  (push_w[g]),
      .pop_i   (pop_w[g]),
      .din_i   (in_data),
      .dout_o  (data_out[8*g +: 8]),
      .empty_o (empty_w[g]),
      .free_o  (free_w[g])
    );
    assign data_vld[g] = !empty_w[g];
    assign pop_w[g]    = !empty_w[g] && !suspend[g];
  end

  // Input packet FSM: header classification, payload count, running parity
  // and the registered one-cycle parity-error pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      par_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= ev_par;
      case (state_q)
        IDLE: begin
          if (in_data_vld) begin
            if (hdr_illegal || hdr_oversize) begin
              rem_q   <= (HDR_LEN_W+1)'(hdr_len) + 1'b1;
              state_q <= DROP;
            end else if (space_ok) begin
              tgt_q   <= hdr_addr;
              len_q   <= hdr_len;
              rem_q   <= (HDR_LEN_W+1)'(hdr_len);
              par_q   <= in_data;
              state_q <= (hdr_len == '0) ? PAR : FWD;
            end else begin
              tgt_q   <= hdr_addr;
              len_q   <= hdr_len;
              state_q <= WAIT_SPACE;
            end
          end
        end
        WAIT_SPACE: begin
          if (space_ok) state_q <= IDLE;
        end
        FWD: begin
          if (in_data_vld) begin
            par_q <= par_q ^ in_data;
            rem_q <= rem_q - 1'b1;
            if (rem_q == (HDR_LEN_W+1)'(1)) state_q <= PAR;
          end
        end
        PAR: begin
          if (in_data_vld) state_q <= IDLE;
        end
        DROP: begin
          if (in_data_vld) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == (HDR_LEN_W+1)'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign error = err_q;

`ifdef YAPP_STATS_EN
  logic             ev_ill;
  logic             ev_len;
  logic [CNT_W-1:0] par_cnt_q;
  logic [CNT_W-1:0] len_cnt_q;
  logic [CNT_W-1:0] ill_cnt_q;

  // Illegal address wins over oversize, so each header bumps at most one counter.
  assign ev_ill = (state_q == IDLE) && in_data_vld && hdr_illegal;
  assign ev_len = (state_q == IDLE) && in_data_vld && !hdr_illegal && hdr_oversize;

  // Saturating event counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      par_cnt_q <= '0;
      len_cnt_q <= '0;
      ill_cnt_q <= '0;
    end else begin
      if (ev_par) par_cnt_q <= sat_inc(par_cnt_q);
      if (ev_len) len_cnt_q <= sat_inc(len_cnt_q);
      if (ev_ill) ill_cnt_q <= sat_inc(ill_cnt_q);
    end
  end

  assign parity_err_cnt = par_cnt_q;
  assign len_err_cnt    = len_cnt_q;
  assign ill_addr_cnt   = ill_cnt_q;
`else
  assign parity_err_cnt = '0;
  assign len_err_cnt    = '0;
  assign ill_addr_cnt   = '0;
`endif

endmodule

// File: tb/tb_yapp_router_mc.sv
// Self-checking bench for yapp_router_mc: packet-level reference model with
// per-channel expected-byte queues, per-cycle output comparison, directed
// scenarios with literal expectations, and a randomized traffic phase.
module tb_yapp_router_mc;

  localparam int NC    = 3;
  localparam int DEPTH = 128;
`ifdef YAPP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      in_data = '0;
  logic            in_data_vld = 1'b0;
  logic            in_suspend;
  logic            error;
  logic [NC-1:0]   chan_en = '1;
  logic [5:0]      max_pkt_len = 6'd63;
  logic [8*NC-1:0] data_out;
  logic [NC-1:0]   data_vld;
  logic [NC-1:0]   suspend = '0;
  logic [7:0]      pcnt, lcnt, icnt;

  yapp_router_mc #(.NUM_CHAN(NC), .FIFO_DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_data        (in_data),
    .in_data_vld    (in_data_vld),
    .in_suspend     (in_suspend),
    .error          (error),
    .chan_en        (chan_en),
    .max_pkt_len    (max_pkt_len),
    .data_out       (data_out),
    .data_vld       (data_vld),
    .suspend        (suspend),
    .parity_err_cnt (pcnt),
    .len_err_cnt    (lcnt),
    .ill_addr_cnt   (icnt)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endfunction

  task automatic abort_run(input string nm);
    chk(1'b0, nm, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "run aborted");
  endtask

  // Reference model state
  logic [7:0] chq [NC][$];   // bytes expected to still be in each channel FIFO
  logic [7:0] obs [NC][$];   // bytes observed leaving each channel
  int m_ill = 0, m_len = 0, m_par = 0;
  bit exp_err = 1'b0;
  int err_pulses = 0;

  // Driver-to-model sideband describing the byte currently on the input
  int drv_dest = -1;
  int drv_kind = 0;   // 0 legal, 1 illegal address/disabled, 2 oversized
  bit drv_hdr  = 1'b0;
  bit drv_last = 1'b0;
  bit drv_bad  = 1'b0;
  bit drv_acc  = 1'b0;

  bit            susp_rand  = 1'b0;
  logic [NC-1:0] susp_force = '0;
  logic [7:0]    pay[$];

  // Receiver stall stimulus, changed away from both clock edges
  always @(posedge clock) begin
    #2;
    if (susp_rand) suspend = NC'($urandom) & NC'($urandom);
    else           suspend = susp_force;
  end

  // Model update at each active edge
  always @(posedge clock) begin
    if (!reset) begin
      for (int c = 0; c < NC; c++) chq[c].delete();
      m_ill = 0; m_len = 0; m_par = 0;
      exp_err = 1'b0;
    end else begin
      for (int c = 0; c < NC; c++)
        if (chq[c].size() > 0 && !suspend[c]) void'(chq[c].pop_front());
      exp_err = 1'b0;
      if (drv_acc) begin
        if (drv_hdr && drv_kind == 1 && m_ill < 255) m_ill++;
        if (drv_hdr && drv_kind == 2 && m_len < 255) m_len++;
        if (drv_dest >= 0) chq[drv_dest].push_back(in_data);
        if (drv_last && drv_bad && drv_dest >= 0) begin
          exp_err = 1'b1;
          if (m_par < 255) m_par++;
        end
      end
    end
  end

  // Per-cycle output comparison on the inactive edge
  always @(negedge clock) begin
    if (reset) begin
      for (int c = 0; c < NC; c++) begin
        chk(data_vld[c] === (chq[c].size() != 0), $sformatf("data_vld%0d", c),
            data_vld[c], chq[c].size() != 0);
        if (chq[c].size() != 0)
          chk(data_out[8*c +: 8] === chq[c][0], $sformatf("data_out%0d", c),
              data_out[8*c +: 8], chq[c][0]);
        if (data_vld[c] && !suspend[c]) obs[c].push_back(data_out[8*c +: 8]);
      end
      chk(error === exp_err, "error", error, exp_err);
      if (error) err_pulses++;
      chk(pcnt === 8'(STATS ? m_par : 0), "parity_err_cnt", pcnt, STATS ? m_par : 0);
      chk(lcnt === 8'(STATS ? m_len : 0), "len_err_cnt", lcnt, STATS ? m_len : 0);
      chk(icnt === 8'(STATS ? m_ill : 0), "ill_addr_cnt", icnt, STATS ? m_ill : 0);
    end
  end

  // Present one byte (called just after a negedge) and hold it until accepted.
  // For a legal header, ch is its channel and need its len+2.
  task automatic put_byte(input logic [7:0] b, input int need, input int ch);
    int waited, ready, fr;
    in_data = b; in_data_vld = 1'b1;
    waited = 0; ready = 0;
    forever begin
      #1;
      if (ch >= 0) begin
        fr = DEPTH - chq[ch].size();
        if (fr < need)        chk(in_suspend === 1'b1, "hdr_hold", in_suspend, 1);
        else if (waited == 0) chk(in_suspend === 1'b0, "hdr_admit", in_suspend, 0);
        else if (ready > 3)   abort_run("hdr_admit_timeout");
        if (fr >= need) ready++;
      end else begin
        chk(in_suspend === 1'b0, "no_stall", in_suspend, 0);
      end
      drv_acc = !in_suspend;
      if (!in_suspend) break;
      waited++;
      if (waited > 20000) abort_run("hdr_wait_timeout");
      @(negedge clock);
    end
    @(negedge clock);
    in_data_vld = 1'b0;
    drv_acc = 1'b0;
  endtask

  // Send a whole packet; payload from pay[] if it has len entries, else random.
  task automatic send_pkt(input logic [7:0] hdr, input bit bad, input int gapprob);
    int addr, len, kind, dest;
    logic [7:0] p;
    logic [7:0] bytes[$];
    addr = int'(hdr[1:0]);
    len  = int'(hdr[7:2]);
    if (addr >= NC)             kind = 1;
    else if (!chan_en[addr])    kind = 1;
    else if (len > max_pkt_len) kind = 2;
    else                        kind = 0;
    dest = (kind == 0) ? addr : -1;
    if (pay.size() != len) begin
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    end
    p = hdr;
    bytes.push_back(hdr);
    foreach (pay[i]) begin p ^= pay[i]; bytes.push_back(pay[i]); end
    bytes.push_back(bad ? (p ^ 8'h01) : p);
    pay.delete();
    for (int i = 0; i < bytes.size(); i++) begin
      if (gapprob > 0 && $urandom_range(99) < gapprob)
        repeat ($urandom_range(1, 3)) @(negedge clock);
      drv_hdr  = (i == 0);
      drv_kind = kind;
      drv_dest = dest;
      drv_last = (i == bytes.size() - 1);
      drv_bad  = bad;
      if (i == 0 && kind == 0) put_byte(bytes[i], len + 2, dest);
      else                     put_byte(bytes[i], 0, -1);
    end
    drv_hdr = 1'b0; drv_last = 1'b0; drv_dest = -1;
  endtask

  task automatic drain();
    int tot;
    susp_rand = 1'b0; susp_force = '0;
    for (int i = 0; i < 3000; i++) begin
      tot = 0;
      for (int c = 0; c < NC; c++) tot += chq[c].size();
      if (tot == 0) break;
      @(negedge clock);
    end
    chk(tot == 0, "drain_timeout", tot, 0);
    repeat (3) @(negedge clock);
  endtask

  task automatic chk_obs(input int c, input int base, input logic [7:0] e[$], input string nm);
    chk(obs[c].size() - base == e.size(), {nm, "_len"}, obs[c].size() - base, e.size());
    for (int i = 0; i < e.size() && base + i < obs[c].size(); i++)
      chk(obs[c][base+i] === e[i], $sformatf("%s_b%0d", nm, i), obs[c][base+i], e[i]);
  endtask

  initial begin : watchdog
    #900000;
    abort_run("global_timeout");
  end

  initial begin : main
    logic [7:0] eq[$];
    int b0, b1, b2, ep;
    logic [7:0] h;
    int a, l;

    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk(data_vld === '0, "rst_data_vld", data_vld, 0);
    chk(error === 1'b0, "rst_error", error, 0);
    chk(in_suspend === 1'b0, "rst_in_suspend", in_suspend, 0);
    chk(icnt === 8'd0 && lcnt === 8'd0 && pcnt === 8'd0, "rst_counters", icnt + lcnt + pcnt, 0);
    @(negedge clock);

    // Basic packet to channel 1
    b1 = obs[1].size(); ep = err_pulses;
    pay = '{8'h01, 8'h02, 8'h03};
    send_pkt(8'h0D, 1'b0, 0);
    drain();
    eq = '{8'h0D, 8'h01, 8'h02, 8'h03, 8'h0D};
    chk_obs(1, b1, eq, "t1_ch1");
    chk(err_pulses == ep, "t1_no_error", err_pulses - ep, 0);
    chk(icnt === 8'd0, "t1_ill_cnt", icnt, 0);

    // Illegal address dropped, then a legal packet to channel 2
    b0 = obs[0].size(); b1 = obs[1].size(); b2 = obs[2].size();
    pay = '{8'hAA, 8'hBB, 8'hCC};
    send_pkt(8'h0F, 1'b0, 0);
    pay = '{8'hAA, 8'h55};
    send_pkt(8'h0A, 1'b0, 0);
    drain();
    chk(icnt === 8'(STATS ? 1 : 0), "t2_ill_cnt", icnt, STATS ? 1 : 0);
    eq = '{8'h0A, 8'hAA, 8'h55, 8'hF5};
    chk_obs(2, b2, eq, "t2_ch2");
    chk(obs[0].size() == b0 && obs[1].size() == b1, "t2_no_stray", obs[0].size() + obs[1].size() - b0 - b1, 0);

    // Oversized dropped, then admitted with a larger limit
    b0 = obs[0].size();
    max_pkt_len = 6'd4;
    pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_pkt(8'h14, 1'b0, 0);
    drain();
    chk(lcnt === 8'(STATS ? 1 : 0), "t3_len_cnt", lcnt, STATS ? 1 : 0);
    chk(obs[0].size() == b0, "t3_dropped", obs[0].size() - b0, 0);
    max_pkt_len = 6'd5;
    pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_pkt(8'h14, 1'b0, 0);
    drain();
    eq = '{8'h14, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h15};
    chk_obs(0, b0, eq, "t3_ch0");
    max_pkt_len = 6'd63;

    // Bad parity: delivered, single error pulse
    b2 = obs[2].size(); ep = err_pulses;
    pay = '{8'h10, 8'h20};
    send_pkt(8'h0A, 1'b1, 0);
    drain();
    chk(err_pulses - ep == 1, "t4_error_pulses", err_pulses - ep, 1);
    chk(pcnt === 8'(STATS ? 1 : 0), "t4_par_cnt", pcnt, STATS ? 1 : 0);
    eq = '{8'h0A, 8'h10, 8'h20, 8'h3B};
    chk_obs(2, b2, eq, "t4_ch2");

    // Two max-length packets to a stalled channel 0
    b0 = obs[0].size();
    susp_force = 3'b001;
    @(negedge clock);
    for (int i = 0; i < 63; i++) pay.push_back(8'(i));
    send_pkt(8'hFC, 1'b0, 0);
    fork
      begin
        for (int i = 0; i < 63; i++) pay.push_back(8'(i) ^ 8'h80);
        send_pkt(8'hFC, 1'b0, 0);
      end
      begin
        repeat (100) @(negedge clock);
        #1;
        chk(in_suspend === 1'b1, "t5_held", in_suspend, 1);
        susp_force = '0;
      end
    join
    drain();
    eq.delete();
    eq.push_back(8'hFC);
    for (int i = 0; i < 63; i++) eq.push_back(8'(i));
    eq.push_back(8'hC3);
    eq.push_back(8'hFC);
    for (int i = 0; i < 63; i++) eq.push_back(8'(i) ^ 8'h80);
    eq.push_back(8'h43);
    chk_obs(0, b0, eq, "t5_ch0");

    // Randomized traffic with random stalls, gaps, enables and limits
    susp_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if (n % 10 == 0) begin
        chan_en     = NC'($urandom);
        max_pkt_len = 6'($urandom_range(8, 63));
      end
      a = $urandom_range(0, 3);
      l = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 12);
      h = {l[5:0], a[1:0]};
      send_pkt(h, ($urandom_range(0, 7) == 0), 20);
    end
    drain();
    chan_en = '1;
    max_pkt_len = 6'd63;

    // Reset in the middle of a payload
    drv_dest = 1; drv_kind = 0; drv_hdr = 1'b1;
    put_byte(8'h0D, 5, 1);
    drv_hdr = 1'b0;
    put_byte(8'h01, 0, -1);
    put_byte(8'h02, 0, -1);
    reset = 1'b0;
    drv_dest = -1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk(data_vld === '0, "t6_data_vld", data_vld, 0);
    chk(icnt === 8'd0 && lcnt === 8'd0 && pcnt === 8'd0, "t6_counters", icnt + lcnt + pcnt, 0);
    @(negedge clock);
    b1 = obs[1].size();
    pay = '{8'h11, 8'h22};
    send_pkt(8'h09, 1'b0, 0);
    drain();
    eq = '{8'h09, 8'h11, 8'h22, 8'h3A};
    chk_obs(1, b1, eq, "t6_ch1");

    // Counter saturation
    for (int n = 0; n < 256; n++) send_pkt(8'h03, 1'b0, 0);
    drain();
    chk(icnt === 8'(STATS ? 255 : 0), "t7_ill_sat", icnt, STATS ? 255 : 0);
    chk(lcnt === 8'd0, "t7_len_cnt", lcnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
